fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage pipeline. Holds the program counter, reads 16-bit words from instruction memory and assembles one- and two-word instructions. Presents one registered instruction packet per cycle to the fetch/decode pipeline buffer. Handles stall and taken-branch redirect from later stages.

---
 rtl/fetch_stage.sv | 144 ++++++++++++++
 tb/tb_fetch_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: holds the PC, reads 16-bit words from instruction
// memory, assembles one- and two-word instructions and presents one
// registered packet per cycle to the fetch/decode buffer.
//
// Flow control: there is no ready input. out_valid qualifies the packet in the
// current cycle; the downstream side applies back-pressure only through
// `stall`, which freezes every register (outputs included) for as long as it
// is high. `redirect` beats `stall` and flushes any half-assembled
// instruction, emitting a bubble.
//
// dbg_state exposes the assembly FSM: 0 = FIRST (expecting an opcode word),
// 1 = SECOND (expecting the immediate word of a two-word instruction).
module fetch_stage #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic            out_valid,
    output logic [15:0]     out_instr,
    output logic [15:0]     out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            dbg_state
);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_hold_instr;
    logic [PC_W-1:0] r_hold_pc;
    logic            r_out_valid;
    logic [15:0]     r_out_instr;
    logic [15:0]     r_out_imm;
    logic [PC_W-1:0] r_out_pc;

    state_t          w_state_nxt;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_inc;
    logic [15:0]     w_hold_instr_nxt;
    logic [PC_W-1:0] w_hold_pc_nxt;
    logic            w_out_valid_nxt;
    logic [15:0]     w_out_instr_nxt;
    logic [15:0]     w_out_imm_nxt;
    logic [PC_W-1:0] w_out_pc_nxt;

    // PC increment wraps naturally modulo 2^PC_W
    assign w_pc_inc  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign imem_addr = r_pc;
    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;
    assign out_imm   = r_out_imm;
    assign out_pc    = r_out_pc;
    assign dbg_state = r_state;

    // Next-state and packet assembly: defaults hold everything (stall case)
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_hold_instr_nxt = r_hold_instr;
        w_hold_pc_nxt    = r_hold_pc;
        w_out_valid_nxt  = r_out_valid;
        w_out_instr_nxt  = r_out_instr;
        w_out_imm_nxt    = r_out_imm;
        w_out_pc_nxt     = r_out_pc;

        if (redirect) begin
            // Abandon any half-assembled instruction and refetch from target
            w_pc_nxt         = redirect_pc;
            w_state_nxt      = ST_FIRST;
            w_hold_instr_nxt = '0;
            w_hold_pc_nxt    = '0;
            w_out_valid_nxt  = 1'b0;
            w_out_instr_nxt  = '0;
            w_out_imm_nxt    = '0;
            w_out_pc_nxt     = '0;
        end else if (!stall) begin
            w_pc_nxt = w_pc_inc;
            case (r_state)
                ST_FIRST: begin
                    if (imem_data[15]) begin
                        // Opcode of a two-word instruction: park it, emit bubble
                        w_hold_instr_nxt = imem_data;
                        w_hold_pc_nxt    = r_pc;
                        w_state_nxt      = ST_SECOND;
                        w_out_valid_nxt  = 1'b0;
                        w_out_instr_nxt  = '0;
                        w_out_imm_nxt    = '0;
                        w_out_pc_nxt     = '0;
                    end else begin
                        w_out_valid_nxt = 1'b1;
                        w_out_instr_nxt = imem_data;
                        w_out_imm_nxt   = '0;
                        w_out_pc_nxt    = r_pc;
                    end
                end
                ST_SECOND: begin
                    // Current word is the immediate; its bit 15 has no meaning
                    w_out_valid_nxt = 1'b1;
                    w_out_instr_nxt = r_hold_instr;
                    w_out_imm_nxt   = imem_data;
                    w_out_pc_nxt    = r_hold_pc;
                    w_state_nxt     = ST_FIRST;
                end
                default: begin
                    w_state_nxt = ST_FIRST;
                end
            endcase
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_FIRST;
            r_pc         <= RESET_PC;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_imm    <= '0;
            r_out_pc     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_hold_pc    <= w_hold_pc_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_imm    <= w_out_imm_nxt;
            r_out_pc     <= w_out_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed steps followed by a randomized run,
// all checked against a packet-level reference model of the fetch rules.
// A second, 4-bit-PC instance covers PC wrap-around and a non-zero RESET_PC.
module tb_fetch_stage;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (PC_W = 32) ----------------
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [15:0] imem_data;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_imm;
    logic [31:0] out_pc;
    logic        dbg_state;

    logic [15:0] mem [256];
    assign imem_data = mem[imem_addr[7:0]];

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
        .out_valid(out_valid), .out_instr(out_instr), .out_imm(out_imm),
        .out_pc(out_pc), .dbg_state(dbg_state)
    );

    // ---------------- small DUT (PC_W = 4, reset at 0xF) ----------------
    logic        b_rst = 1'b1;
    logic        b_stall = 1'b0;
    logic        b_redirect = 1'b0;
    logic [3:0]  b_redirect_pc = '0;
    logic [3:0]  b_imem_addr;
    logic [15:0] b_imem_data;
    logic        b_out_valid;
    logic [15:0] b_out_instr;
    logic [15:0] b_out_imm;
    logic [3:0]  b_out_pc;
    logic        b_dbg_state;

    logic [15:0] mem4 [16];
    assign b_imem_data = mem4[b_imem_addr];

    fetch_stage #(.PC_W(4), .RESET_PC(4'hF)) u_dut4 (
        .clk(clk), .rst(b_rst), .stall(b_stall), .redirect(b_redirect),
        .redirect_pc(b_redirect_pc), .imem_addr(b_imem_addr), .imem_data(b_imem_data),
        .out_valid(b_out_valid), .out_instr(b_out_instr), .out_imm(b_out_imm),
        .out_pc(b_out_pc), .dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Fetch address, a queue holding at most one parked {pc, opcode} of a
    // two-word instruction, and the packet expected on the outputs.
    logic [31:0] m_pc = '0;
    logic [47:0] half_q[$];
    logic        e_valid = 1'b0;
    logic [15:0] e_instr = '0;
    logic [15:0] e_imm = '0;
    logic [31:0] e_pc = '0;

    task automatic clear_packet();
        e_valid = 1'b0;
        e_instr = '0;
        e_imm   = '0;
        e_pc    = '0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        logic [47:0] h;
        if (rst) begin
            m_pc = 32'h0;
            half_q.delete();
            clear_packet();
        end else if (redirect) begin
            m_pc = redirect_pc;
            half_q.delete();
            clear_packet();
        end else if (!stall) begin
            w = mem[m_pc[7:0]];
            if (half_q.size() != 0) begin
                h = half_q.pop_front();
                e_valid = 1'b1;
                e_instr = h[15:0];
                e_imm   = w;
                e_pc    = h[47:16];
            end else if (w[15]) begin
                half_q.push_back({m_pc, w});
                clear_packet();
            end else begin
                e_valid = 1'b1;
                e_instr = w;
                e_imm   = '0;
                e_pc    = m_pc;
            end
            m_pc = m_pc + 32'd1;
        end
    endtask

    // ---------------- driver ----------------
    // Apply one cycle of controls, advance the model, then compare after the edge.
    task automatic tick(input logic r, input logic s, input logic d, input logic [31:0] t);
        rst         = r;
        stall       = s;
        redirect    = d;
        redirect_pc = t;
        model_step();
        @(posedge clk);
        #1;
        check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
        check("out_instr", {16'b0, out_instr}, {16'b0, e_instr});
        check("out_imm",   {16'b0, out_imm},   {16'b0, e_imm});
        check("out_pc",    out_pc, e_pc);
        check("imem_addr", imem_addr, m_pc);
        check("state",     {31'b0, dbg_state}, {31'b0, (half_q.size() != 0)});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic r, s, d;
        logic [31:0] t;

        clear_mem();
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        mem4[15] = 16'h9ABC;
        mem4[0]  = 16'h7777;
        mem4[1]  = 16'h0011;

        // Reset state
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 32'h55);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);

        // 1: single-word stream
        mem[0] = 16'h0101; mem[1] = 16'h0202; mem[2] = 16'h0303; mem[3] = 16'h0404;
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            check("t1_valid", {31'b0, out_valid}, 32'h1);
            check("t1_instr", {16'b0, out_instr}, 32'h0101 * (i + 1));
            check("t1_pc", out_pc, i);
        end

        // 2: two-word instruction
        clear_mem();
        mem[0] = 16'h8A00; mem[1] = 16'h1234; mem[2] = 16'h0005;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("t2_bubble", {31'b0, out_valid}, 32'h0);
        tick(0, 0, 0, 0);
        check("t2_instr", {16'b0, out_instr}, 32'h8A00);
        check("t2_imm", {16'b0, out_imm}, 32'h1234);
        check("t2_pc", out_pc, 32'h0);
        tick(0, 0, 0, 0);
        check("t2_next_instr", {16'b0, out_instr}, 32'h0005);
        check("t2_next_pc", out_pc, 32'h2);

        // 3: stall for 3 cycles while in SECOND
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            check("t3_addr_frozen", imem_addr, 32'h1);
            check("t3_valid_frozen", {31'b0, out_valid}, 32'h0);
        end
        tick(0, 0, 0, 0);
        check("t3_pkt_instr", {16'b0, out_instr}, 32'h8A00);
        check("t3_pkt_imm", {16'b0, out_imm}, 32'h1234);
        tick(0, 0, 0, 0);
        check("t3_no_dup", {16'b0, out_instr}, 32'h0005);

        // 4: redirect in SECOND while stalled
        mem[8'h40] = 16'h0042;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 1, 32'h40);
        check("t4_bubble", {31'b0, out_valid}, 32'h0);
        check("t4_addr", imem_addr, 32'h40);
        tick(0, 0, 0, 0);
        check("t4_pc", out_pc, 32'h40);
        check("t4_instr", {16'b0, out_instr}, 32'h0042);

        // 6: reset in SECOND while stalled, and reset right after a valid packet
        tick(0, 0, 1, 32'h0);
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 0);
        check("t6_valid", {31'b0, out_valid}, 32'h0);
        check("t6_addr", imem_addr, 32'h0);
        check("t6_state", {31'b0, dbg_state}, 32'h0);
        tick(0, 0, 1, 32'h2);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        check("t6b_instr", {16'b0, out_instr}, 32'h0);
        check("t6b_pc", out_pc, 32'h0);

        // 5: PC wrap on the 4-bit instance (held in reset until now)
        check("t5_rst_valid", {31'b0, b_out_valid}, 32'h0);
        check("t5_rst_addr", {28'b0, b_imem_addr}, 32'hF);
        check("t5_rst_state", {31'b0, b_dbg_state}, 32'h0);
        b_rst = 1'b0;
        tick(0, 0, 0, 0);
        check("t5_bubble", {31'b0, b_out_valid}, 32'h0);
        check("t5_wrap_addr", {28'b0, b_imem_addr}, 32'h0);
        check("t5_second", {31'b0, b_dbg_state}, 32'h1);
        tick(0, 0, 0, 0);
        check("t5_valid", {31'b0, b_out_valid}, 32'h1);
        check("t5_instr", {16'b0, b_out_instr}, 32'h9ABC);
        check("t5_imm", {16'b0, b_out_imm}, 32'h7777);
        check("t5_pc", {28'b0, b_out_pc}, 32'hF);
        check("t5_next_addr", {28'b0, b_imem_addr}, 32'h1);
        tick(0, 0, 0, 0);
        check("t5_next_instr", {16'b0, b_out_instr}, 32'h0011);
        check("t5_next_pc", {28'b0, b_out_pc}, 32'h1);

        // Randomized run against the model
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        tick(1, 0, 0, 0);
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 3) mem[$urandom_range(0, 255)] = 16'($urandom);
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 25);
            d = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 99) < 10) t = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else t = 32'($urandom_range(0, 255));
            tick(r, s, d, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
